// File: rtl/issue_scoreboard.sv
// In-order single-issue stage: a register scoreboard and unit-busy tracking gate dispatch
// of the instruction held in decode. Operands are read from the register file on dispatch.
module issue_scoreboard #(
    parameter int unsigned NUM_FU   = 4,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        id_is_valid,
    input  logic [1:0]  id_is_numop,
    input  logic [1:0]  id_is_fununit,
    input  logic [31:0] id_is_addra,
    input  logic [31:0] id_is_addrb,
    input  logic [4:0]  id_is_regdest,
    input  logic        id_is_writereg,
    input  logic [2:0]  id_is_aluop,
    input  logic [1:0]  id_is_shiftop,
    input  logic        id_is_selalushift,
    input  logic        id_is_selimregb,
    input  logic        id_is_unsig,
    input  logic        id_is_readmem,
    input  logic        id_is_writemem,
    input  logic        id_is_selwsource,
    input  logic        id_is_writeov,
    input  logic [31:0] id_is_imedext,

    output logic [4:0]  is_reg_addra,
    output logic [4:0]  is_reg_addrb,
    input  logic [31:0] reg_is_dataa,
    input  logic [31:0] reg_is_datab,

    output logic        is_if_stall,

    input  logic        wb_is_valid,
    input  logic [1:0]  wb_is_fununit,
    input  logic        wb_is_writereg,
    input  logic [4:0]  wb_is_regdest,

    output logic        is_ex_valid,
    output logic [1:0]  is_ex_fununit,
    output logic [4:0]  is_ex_regdest,
    output logic        is_ex_writereg,
    output logic [2:0]  is_ex_aluop,
    output logic [1:0]  is_ex_shiftop,
    output logic        is_ex_selalushift,
    output logic        is_ex_selimregb,
    output logic        is_ex_unsig,
    output logic        is_ex_readmem,
    output logic        is_ex_writemem,
    output logic        is_ex_selwsource,
    output logic        is_ex_writeov,
    output logic [31:0] is_ex_imedext,
    output logic [31:0] is_ex_dataa,
    output logic [31:0] is_ex_datab
);

    logic [NUM_REGS-1:0] pending_q, pending_d, eff_pending, wb_reg_clr, issue_reg_set;
    logic [NUM_FU-1:0]   fu_busy_q, fu_busy_d, eff_busy, wb_fu_clr, issue_fu_set;
    logic                raw_a, raw_b, waw, struct_haz, can_issue;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{id_is_addra[31:5], id_is_addrb[31:5]};

    assign is_reg_addra = id_is_addra[4:0];
    assign is_reg_addrb = id_is_addrb[4:0];

    always_comb begin
        wb_reg_clr    = '0;
        wb_fu_clr     = '0;
        issue_reg_set = '0;
        issue_fu_set  = '0;

        if (wb_is_valid && wb_is_writereg) wb_reg_clr = NUM_REGS'(1) << wb_is_regdest;
        if (wb_is_valid)                   wb_fu_clr  = NUM_FU'(1) << wb_is_fununit;

        // Writeback completing this cycle is already visible to the hazard check.
        eff_pending = pending_q & ~wb_reg_clr;
        eff_busy    = fu_busy_q & ~wb_fu_clr;

        raw_a      = (id_is_numop != 2'd0) && eff_pending[id_is_addra[4:0]];
        raw_b      = (id_is_numop == 2'd2) && eff_pending[id_is_addrb[4:0]];
        waw        = id_is_writereg && (id_is_regdest != 5'd0) && eff_pending[id_is_regdest];
        struct_haz = eff_busy[id_is_fununit];

        can_issue   = id_is_valid && !raw_a && !raw_b && !waw && !struct_haz;
        is_if_stall = id_is_valid && !can_issue;

        if (can_issue) begin
            issue_fu_set = NUM_FU'(1) << id_is_fununit;
            if (id_is_writereg && (id_is_regdest != 5'd0)) begin
                issue_reg_set = NUM_REGS'(1) << id_is_regdest;
            end
        end

        // Set is applied after clear so a same-cycle issue wins over writeback.
        pending_d    = eff_pending | issue_reg_set;
        pending_d[0] = 1'b0;
        fu_busy_d    = eff_busy | issue_fu_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            fu_busy_q <= '0;
        end else begin
            pending_q <= pending_d;
            fu_busy_q <= fu_busy_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_ex_valid       <= 1'b0;
            is_ex_fununit     <= '0;
            is_ex_regdest     <= '0;
            is_ex_writereg    <= 1'b0;
            is_ex_aluop       <= '0;
            is_ex_shiftop     <= '0;
            is_ex_selalushift <= 1'b0;
            is_ex_selimregb   <= 1'b0;
            is_ex_unsig       <= 1'b0;
            is_ex_readmem     <= 1'b0;
            is_ex_writemem    <= 1'b0;
            is_ex_selwsource  <= 1'b0;
            is_ex_writeov     <= 1'b0;
            is_ex_imedext     <= '0;
            is_ex_dataa       <= '0;
            is_ex_datab       <= '0;
        end else begin
            is_ex_valid <= can_issue;
            if (can_issue) begin
                is_ex_fununit     <= id_is_fununit;
                is_ex_regdest     <= id_is_regdest;
                is_ex_writereg    <= id_is_writereg;
                is_ex_aluop       <= id_is_aluop;
                is_ex_shiftop     <= id_is_shiftop;
                is_ex_selalushift <= id_is_selalushift;
                is_ex_selimregb   <= id_is_selimregb;
                is_ex_unsig       <= id_is_unsig;
                is_ex_readmem     <= id_is_readmem;
                is_ex_writemem    <= id_is_writemem;
                is_ex_selwsource  <= id_is_selwsource;
                is_ex_writeov     <= id_is_writeov;
                is_ex_imedext     <= id_is_imedext;
                is_ex_dataa       <= reg_is_dataa;
                is_ex_datab       <= reg_is_datab;
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed vector table, async-reset corner, then random
// stimulus against an array-based scoreboard model.
module tb_issue_scoreboard;

    logic        clock, reset;
    logic        id_is_valid, id_is_writereg;
    logic [1:0]  id_is_numop, id_is_fununit, id_is_shiftop;
    logic [31:0] id_is_addra, id_is_addrb, id_is_imedext;
    logic [4:0]  id_is_regdest;
    logic [2:0]  id_is_aluop;
    logic        id_is_selalushift, id_is_selimregb, id_is_unsig, id_is_readmem;
    logic        id_is_writemem, id_is_selwsource, id_is_writeov;
    logic [4:0]  is_reg_addra, is_reg_addrb;
    logic [31:0] reg_is_dataa, reg_is_datab;
    logic        is_if_stall;
    logic        wb_is_valid, wb_is_writereg;
    logic [1:0]  wb_is_fununit;
    logic [4:0]  wb_is_regdest;
    logic        is_ex_valid, is_ex_writereg;
    logic [1:0]  is_ex_fununit, is_ex_shiftop;
    logic [4:0]  is_ex_regdest;
    logic [2:0]  is_ex_aluop;
    logic        is_ex_selalushift, is_ex_selimregb, is_ex_unsig, is_ex_readmem;
    logic        is_ex_writemem, is_ex_selwsource, is_ex_writeov;
    logic [31:0] is_ex_imedext, is_ex_dataa, is_ex_datab;

    issue_scoreboard dut (
        .clock(clock), .reset(reset),
        .id_is_valid(id_is_valid), .id_is_numop(id_is_numop), .id_is_fununit(id_is_fununit),
        .id_is_addra(id_is_addra), .id_is_addrb(id_is_addrb), .id_is_regdest(id_is_regdest),
        .id_is_writereg(id_is_writereg), .id_is_aluop(id_is_aluop),
        .id_is_shiftop(id_is_shiftop), .id_is_selalushift(id_is_selalushift),
        .id_is_selimregb(id_is_selimregb), .id_is_unsig(id_is_unsig),
        .id_is_readmem(id_is_readmem), .id_is_writemem(id_is_writemem),
        .id_is_selwsource(id_is_selwsource), .id_is_writeov(id_is_writeov),
        .id_is_imedext(id_is_imedext),
        .is_reg_addra(is_reg_addra), .is_reg_addrb(is_reg_addrb),
        .reg_is_dataa(reg_is_dataa), .reg_is_datab(reg_is_datab),
        .is_if_stall(is_if_stall),
        .wb_is_valid(wb_is_valid), .wb_is_fununit(wb_is_fununit),
        .wb_is_writereg(wb_is_writereg), .wb_is_regdest(wb_is_regdest),
        .is_ex_valid(is_ex_valid), .is_ex_fununit(is_ex_fununit),
        .is_ex_regdest(is_ex_regdest), .is_ex_writereg(is_ex_writereg),
        .is_ex_aluop(is_ex_aluop), .is_ex_shiftop(is_ex_shiftop),
        .is_ex_selalushift(is_ex_selalushift), .is_ex_selimregb(is_ex_selimregb),
        .is_ex_unsig(is_ex_unsig), .is_ex_readmem(is_ex_readmem),
        .is_ex_writemem(is_ex_writemem), .is_ex_selwsource(is_ex_selwsource),
        .is_ex_writeov(is_ex_writeov), .is_ex_imedext(is_ex_imedext),
        .is_ex_dataa(is_ex_dataa), .is_ex_datab(is_ex_datab)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          v;
        bit [1:0]    numop;
        bit [1:0]    fu;
        bit [31:0]   ra;
        bit [31:0]   rb;
        bit [4:0]    rd;
        bit          wr;
        bit [2:0]    aluop;
        bit [1:0]    shiftop;
        bit [6:0]    flags;
        bit [31:0]   imm;
        bit [31:0]   da;
        bit [31:0]   db;
    } instr_t;

    typedef struct {
        bit       v;
        bit [1:0] fu;
        bit       wr;
        bit [4:0] rd;
    } wb_t;

    typedef struct {
        instr_t in;
        wb_t    wb;
        bit     stall;
        bit     valid;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference state: which registers have an outstanding writer, which units are occupied.
    bit     pend[32];
    bit     busy[4];
    bit     exp_valid;
    instr_t exp_in;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int v, input int numop, input int fu, input int ra,
                                input int rb, input int rd, input int wr,
                                input logic [31:0] da, input logic [31:0] db,
                                input int wbv, input int wbfu, input int wbwr, input int wbrd,
                                input int stall, input int valid);
        vec_t t;
        t.in.v       = v[0];
        t.in.numop   = numop[1:0];
        t.in.fu      = fu[1:0];
        t.in.ra      = 32'h5a5a_0000 | 32'(ra);
        t.in.rb      = 32'ha5a5_0000 | 32'(rb);
        t.in.rd      = rd[4:0];
        t.in.wr      = wr[0];
        t.in.aluop   = rd[2:0] ^ 3'b101;
        t.in.shiftop = fu[1:0];
        t.in.flags   = {v[0], wr[0], numop[1:0], fu[1:0], 1'b1};
        t.in.imm     = da ^ db ^ 32'h1234_0000;
        t.in.da      = da;
        t.in.db      = db;
        t.wb.v       = wbv[0];
        t.wb.fu      = wbfu[1:0];
        t.wb.wr      = wbwr[0];
        t.wb.rd      = wbrd[4:0];
        t.stall      = stall[0];
        t.valid      = valid[0];
        return t;
    endfunction

    task automatic drive(input instr_t in, input wb_t w);
        id_is_valid       = in.v;
        id_is_numop       = in.numop;
        id_is_fununit     = in.fu;
        id_is_addra       = in.ra;
        id_is_addrb       = in.rb;
        id_is_regdest     = in.rd;
        id_is_writereg    = in.wr;
        id_is_aluop       = in.aluop;
        id_is_shiftop     = in.shiftop;
        {id_is_selalushift, id_is_selimregb, id_is_unsig, id_is_readmem,
         id_is_writemem, id_is_selwsource, id_is_writeov} = in.flags;
        id_is_imedext     = in.imm;
        reg_is_dataa      = in.da;
        reg_is_datab      = in.db;
        wb_is_valid       = w.v;
        wb_is_fununit     = w.fu;
        wb_is_writereg    = w.wr;
        wb_is_regdest     = w.rd;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " ex_valid"}, 64'(is_ex_valid), 64'(exp_valid));
        check({tag, " ex_ctrl"},
              64'({is_ex_fununit, is_ex_regdest, is_ex_writereg, is_ex_aluop, is_ex_shiftop,
                   is_ex_selalushift, is_ex_selimregb, is_ex_unsig, is_ex_readmem,
                   is_ex_writemem, is_ex_selwsource, is_ex_writeov, is_ex_imedext}),
              64'({exp_in.fu, exp_in.rd, exp_in.wr, exp_in.aluop, exp_in.shiftop,
                   exp_in.flags, exp_in.imm}));
        check({tag, " ex_data"}, {is_ex_dataa, is_ex_datab}, {exp_in.da, exp_in.db});
    endtask

    // One cycle: entered and left at a negedge.
    task automatic step(input instr_t in, input wb_t w, input bit use_tab, input bit t_stall,
                        input bit t_valid, input string tag);
        bit ep[32];
        bit eb[4];
        bit hazard, iss;
        drive(in, w);
        #1;
        ep = pend;
        eb = busy;
        if (w.v && w.wr) ep[w.rd] = 1'b0;
        if (w.v) eb[w.fu] = 1'b0;
        hazard = (in.numop >= 1 && ep[in.ra[4:0]]) || (in.numop == 2 && ep[in.rb[4:0]]) ||
                 (in.wr && in.rd != 0 && ep[in.rd]) || eb[in.fu];
        iss = in.v && !hazard;
        check({tag, " stall"}, 64'(is_if_stall), 64'(in.v && !iss));
        check({tag, " reg_addr"}, 64'({is_reg_addra, is_reg_addrb}),
              64'({in.ra[4:0], in.rb[4:0]}));
        if (use_tab) begin
            check({tag, " tab_stall"}, 64'(is_if_stall), 64'(t_stall));
            check({tag, " tab_issue"}, 64'(iss), 64'(t_valid));
        end
        @(posedge clock);
        pend = ep;
        busy = eb;
        if (iss) begin
            busy[in.fu] = 1'b1;
            if (in.wr && in.rd != 0) pend[in.rd] = 1'b1;
            exp_in = in;
        end
        exp_valid = iss;
        @(negedge clock);
        check_outputs(tag);
        if (use_tab) check({tag, " tab_ex_valid"}, 64'(is_ex_valid), 64'(t_valid));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        for (int i = 0; i < 4; i++) busy[i] = 1'b0;
        exp_valid = 1'b0;
        exp_in    = '{default: '0};
    endtask

    vec_t   vt[16];
    instr_t ri;
    wb_t    rw;
    vec_t   tmp;

    initial begin
        vt[0]  = mk(1, 2, 0, 1, 2, 3, 1, 5, 7,                 0, 0, 0, 0,  0, 1);
        vt[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                 1, 3, 1, 10, 0, 0);
        vt[2]  = mk(1, 1, 1, 3, 9, 4, 1, 11, 12,               0, 0, 0, 0,  1, 0);
        vt[3]  = mk(1, 1, 1, 3, 9, 4, 1, 11, 12,               0, 0, 0, 0,  1, 0);
        vt[4]  = mk(1, 1, 1, 3, 9, 4, 1, 11, 12,               1, 0, 1, 3,  0, 1);
        vt[5]  = mk(1, 1, 2, 0, 0, 6, 1, 20, 21,               0, 0, 0, 0,  0, 1);
        vt[6]  = mk(1, 1, 2, 0, 0, 7, 1, 22, 23,               0, 0, 0, 0,  1, 0);
        vt[7]  = mk(1, 1, 2, 0, 0, 7, 1, 22, 23,               1, 2, 0, 0,  0, 1);
        vt[8]  = mk(1, 0, 2, 0, 0, 0, 0, 30, 31,               0, 0, 0, 0,  1, 0);
        vt[9]  = mk(1, 0, 3, 0, 0, 0, 1, 40, 41,               0, 0, 0, 0,  0, 1);
        vt[10] = mk(1, 2, 0, 0, 0, 9, 0, 42, 43,               0, 0, 0, 0,  0, 1);
        vt[11] = mk(1, 0, 0, 0, 0, 4, 1, 50, 51,               1, 0, 0, 0,  1, 0);
        vt[12] = mk(1, 0, 0, 0, 0, 4, 1, 50, 51,               0, 0, 0, 0,  1, 0);
        vt[13] = mk(1, 0, 0, 0, 0, 4, 1, 50, 51,               1, 1, 1, 4,  0, 1);
        vt[14] = mk(1, 0, 1, 0, 0, 8, 1, 32'hdeadbeef, 32'h0badf00d, 0, 0, 0, 0, 0, 1);
        vt[15] = mk(1, 1, 1, 6, 0, 9, 1, 60, 61,               0, 0, 0, 0,  1, 0);

        model_reset();
        tmp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(tmp.in, tmp.wb);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset stall", 64'(is_if_stall), 64'd0);
        check_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            step(vt[i].in, vt[i].wb, 1'b1, vt[i].stall, vt[i].valid, $sformatf("vec%0d", i));
        end

        // Reader of a pending register stalls, then reset lands between clock edges.
        drive(vt[15].in, vt[15].wb);
        #1;
        check("pre_reset stall", 64'(is_if_stall), 64'd1);
        check("pre_reset ex_valid", 64'(is_ex_valid), 64'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check("async_reset stall", 64'(is_if_stall), 64'd0);
        check_outputs("async_reset");
        @(negedge clock);
        check("held_reset stall", 64'(is_if_stall), 64'd0);
        check_outputs("held_reset");
        reset = 1'b0;
        step(vt[15].in, vt[15].wb, 1'b1, 1'b0, 1'b1, "post_reset");

        for (int n = 0; n < 1500; n++) begin
            ri.v       = ($urandom_range(0, 3) != 0);
            ri.numop   = 2'($urandom_range(0, 3));
            ri.fu      = 2'($urandom_range(0, 3));
            ri.ra      = {$urandom} & 32'hffff_ffe0 | 32'($urandom_range(0, 7));
            ri.rb      = {$urandom} & 32'hffff_ffe0 | 32'($urandom_range(0, 7));
            ri.rd      = 5'($urandom_range(0, 7));
            ri.wr      = 1'($urandom);
            ri.aluop   = 3'($urandom);
            ri.shiftop = 2'($urandom);
            ri.flags   = 7'($urandom);
            ri.imm     = $urandom;
            ri.da      = $urandom;
            ri.db      = $urandom;
            rw.v       = ($urandom_range(0, 1) != 0);
            rw.fu      = 2'($urandom_range(0, 3));
            rw.wr      = 1'($urandom);
            rw.rd      = 5'($urandom_range(0, 7));
            step(ri, rw, 1'b0, 1'b0, 1'b0, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- In-order single-issue stage directly downstream of the decode stage.
- Takes the decoded instruction held in decode's id_is_* registers and checks operand readiness against a 32-entry register scoreboard. Also checks functional-unit availability.
- Dispatches the instruction to execute with register operands read, or asserts is_if_stall so that decode and fetch hold.
- Writeback completions clear scoreboard and unit-busy state.

Parameters:
NUM_FU, 4, number of functional units; fununit code indexes the unit-busy vector
NUM_REGS, 32, architectural registers tracked; register 0 is never tracked

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
id_is_valid  in  1  decode holds a valid instruction
id_is_numop  in  2  source operand count: 0 none, 1 rs, 2 rs+rt
id_is_fununit  in  2  target functional unit
id_is_addra  in  32  rs index; bits [4:0] used
id_is_addrb  in  32  rt index; bits [4:0] used
id_is_regdest  in  5  destination register
id_is_writereg  in  1  instruction writes regdest
id_is_aluop  in  3  passed through
id_is_shiftop  in  2  passed through
id_is_selalushift, id_is_selimregb, id_is_unsig, id_is_readmem, id_is_writemem, id_is_selwsource, id_is_writeov  in  1 each  passed through
id_is_imedext  in  32  passed through
is_reg_addra  out  5  register-file read address A = id_is_addra[4:0]
is_reg_addrb  out  5  register-file read address B = id_is_addrb[4:0]
reg_is_dataa  in  32  register-file data A
reg_is_datab  in  32  register-file data B
is_if_stall  out  1  hold decode/fetch
wb_is_valid  in  1  a functional unit completes
wb_is_fununit  in  2  completing unit
wb_is_writereg  in  1  completion writes a register
wb_is_regdest  in  5  register written
is_ex_valid  out  1  dispatch pulse to execute
is_ex_fununit, is_ex_regdest, is_ex_writereg, pass-through fields (is_ex_*), is_ex_dataa, is_ex_datab  out  as inputs  registered dispatch bundle

Behaviour:
- State: pending[31:0], with pending[0] hard-wired 0; fu_busy[NUM_FU-1:0].
- Effective state: eff_pending = pending & ~(wb_is_valid & wb_is_writereg ? onehot(wb_is_regdest) : 0). eff_busy = fu_busy & ~(wb_is_valid ? onehot(wb_is_fununit) : 0). Same-cycle writeback release is visible to issue.
- Hazard terms:
  - raw_a = numop>=1 & eff_pending[addra[4:0]].
  - raw_b = numop==2 & eff_pending[addrb[4:0]].
  - waw = writereg & regdest!=0 & eff_pending[regdest].
  - struct = eff_busy[fununit].
- Issue rule: can_issue = id_is_valid & ~raw_a & ~raw_b & ~waw & ~struct.
- is_if_stall = id_is_valid & ~can_issue. This path is combinational, so stall is asserted in the same cycle the hazard is seen.
- On can_issue at a posedge:
  - is_ex_valid<=1 and all is_ex_* fields <= current inputs.
  - is_ex_dataa/datab <= reg_is_dataa/datab.
  - fu_busy[fununit]<=1.
  - pending[regdest]<=1 if writereg & regdest!=0.
- Without issue: is_ex_valid<=0; other is_ex_* fields hold their values.
- Latency: 1 cycle from an accepted instruction to is_ex_valid.
- Each writeback at a posedge clears its pending bit and its fu_busy bit.
- Simultaneous events:
  - Issue set and writeback clear on the same register or unit in one cycle: set wins, so the bit ends up 1.
  - Writeback for a register not pending, or for an idle unit: no effect, no error.
- numop==0 ignores both source indices. Register 0 as a source is never a hazard.
- Reset (asynchronous, any time, including mid-stall): pending=0, fu_busy=0, is_ex_valid=0, all is_ex_* =0, so is_if_stall=0 once inputs are idle.
- No internal buffer. The instruction waits in decode's registers, which hold while is_if_stall=1.

Test Plan:
- Reset, then ADD r3 <- r1,r2 (numop 2, fu 0, valid) with data A=5, B=7 -> next cycle is_ex_valid=1, is_ex_dataa=5, is_ex_datab=7, is_ex_regdest=3; pending[3]=1, fu_busy[0]=1.
- RAW hazard:
  - Setup: r3 pending; instr with rs=3, fu 1, valid.
  - Without writeback -> is_if_stall=1, is_ex_valid=0.
  - Cycle N with wb_is_valid=1, wb_is_regdest=3 -> stall=0 in cycle N, dispatch at N+1.
- Structural hazard: fu 2 busy, new fu-2 load -> stall. Writeback of fu 2 -> issues the same cycle and fu_busy[2] stays 1.
- Destination r0 with writereg=1 -> no pending bit set; a following reader of r0 issues back-to-back with no stall.
- WAW: r5 pending, new instr writes r5 on a free unit -> stall until writeback of r5.
- Assert reset while stalled with pending and busy bits set -> all cleared asynchronously, is_if_stall drops, is_ex_valid=0.
